// File: rtl/line_fifo_ctrl.sv
// ============================================================================
// line_fifo_ctrl : sequences the previous-row line FIFO and emits per-pixel
// neighbour sets {cur, a, b, c} for the PNG filter stage.   Rev 1.0
// ============================================================================
`ifndef SIZE_W_WD
`define SIZE_W_WD 12
`endif
`ifndef SIZE_H_WD
`define SIZE_H_WD 12
`endif
`default_nettype none

module line_fifo_ctrl #(
  parameter int DATA_WD = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [`SIZE_W_WD-1:0] cfg_w_i,
  input  logic [`SIZE_H_WD-1:0] cfg_h_i,
  input  logic                  start_i,
  input  logic                  pix_val_i,
  input  logic [DATA_WD-1:0]    pix_dat_i,
  output logic                  pix_rdy_o,
  output logic                  fifo_wr_val_o,
  output logic [DATA_WD-1:0]    fifo_wr_dat_o,
  output logic                  fifo_rd_val_o,
  input  logic [DATA_WD-1:0]    fifo_rd_dat_i,
  output logic                  out_val_o,
  output logic [DATA_WD-1:0]    out_cur_o,
  output logic [DATA_WD-1:0]    out_a_o,
  output logic [DATA_WD-1:0]    out_b_o,
  output logic [DATA_WD-1:0]    out_c_o,
  output logic                  out_sol_o,
  output logic                  out_eof_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ROW0 = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [`SIZE_W_WD-1:0] W_ONE = 1;
  localparam logic [`SIZE_H_WD-1:0] H_ONE = 1;

  state_t                  state, state_nxt;
  logic [`SIZE_W_WD-1:0]   col;
  logic [`SIZE_H_WD-1:0]   row;
  logic [DATA_WD-1:0]      hold, prev_cur, prev_up;
  logic                    xfer, last_col, last_row, col0;

  assign col0     = (col == '0);
  assign last_col = (col == cfg_w_i - W_ONE);
  assign last_row = (row == cfg_h_i - H_ONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    xfer          = 1'b0;
    pix_rdy_o     = 1'b0;
    fifo_wr_val_o = 1'b0;
    fifo_wr_dat_o = '0;
    fifo_rd_val_o = 1'b0;
    case (state)
      S_IDLE: if (start_i) state_nxt = S_ROW0;
      S_ROW0: begin
        pix_rdy_o     = 1'b1;
        xfer          = pix_val_i;
        fifo_wr_val_o = pix_val_i;
        fifo_wr_dat_o = pix_dat_i;
        if (xfer && last_col) state_nxt = (cfg_h_i > H_ONE) ? S_RD : S_DONE;
      end
      S_RD: begin
        pix_rdy_o     = 1'b1;
        xfer          = pix_val_i;
        fifo_rd_val_o = pix_val_i;
        if (xfer) state_nxt = S_WR;
      end
      S_WR: begin
        fifo_wr_val_o = 1'b1;
        fifo_wr_dat_o = hold;
        state_nxt     = (last_col && last_row) ? S_DONE : S_RD;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      prev_cur  <= '0;
      prev_up   <= '0;
      out_val_o <= 1'b0;
      out_cur_o <= '0;
      out_a_o   <= '0;
      out_b_o   <= '0;
      out_c_o   <= '0;
      out_sol_o <= 1'b0;
      out_eof_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      out_val_o <= 1'b0;
      done_o    <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start_i) begin
            col <= '0;
            row <= '0;
          end
        end
        S_ROW0: begin
          if (xfer) begin
            out_val_o <= 1'b1;
            out_cur_o <= pix_dat_i;
            out_a_o   <= col0 ? '0 : prev_cur;
            out_b_o   <= '0;
            out_c_o   <= '0;
            out_sol_o <= col0;
            out_eof_o <= last_col && last_row;
            prev_cur  <= pix_dat_i;
            col       <= last_col ? '0 : col + W_ONE;
            if (last_col) row <= last_row ? '0 : row + H_ONE;
          end
        end
        S_RD: if (xfer) hold <= pix_dat_i;
        S_WR: begin
          // FIFO read data for this column arrives in this cycle
          out_val_o <= 1'b1;
          out_cur_o <= hold;
          out_a_o   <= col0 ? '0 : prev_cur;
          out_b_o   <= fifo_rd_dat_i;
          out_c_o   <= col0 ? '0 : prev_up;
          out_sol_o <= col0;
          out_eof_o <= last_col && last_row;
          prev_cur  <= hold;
          prev_up   <= fifo_rd_dat_i;
          col       <= last_col ? '0 : col + W_ONE;
          if (last_col) row <= last_row ? '0 : row + H_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_fifo_ctrl.sv
// ============================================================================
// tb_line_fifo_ctrl : randomized bench with a line-FIFO model and an
// image-level neighbour reference.   Rev 1.0
// ============================================================================
`ifndef SIZE_W_WD
`define SIZE_W_WD 12
`endif
`ifndef SIZE_H_WD
`define SIZE_H_WD 12
`endif
`default_nettype none

module tb_line_fifo_ctrl;
  localparam int DW = 32;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [`SIZE_W_WD-1:0] cfg_w_i = '0;
  logic [`SIZE_H_WD-1:0] cfg_h_i = '0;
  logic                  start_i = 1'b0;
  logic                  pix_val_i = 1'b0;
  logic [DW-1:0]         pix_dat_i = '0;
  logic                  pix_rdy_o, fifo_wr_val_o, fifo_rd_val_o;
  logic [DW-1:0]         fifo_wr_dat_o, fifo_rd_dat_i;
  logic                  out_val_o, out_sol_o, out_eof_o, done_o;
  logic [DW-1:0]         out_cur_o, out_a_o, out_b_o, out_c_o;

  line_fifo_ctrl #(.DATA_WD(DW)) dut (
    .clk(clk), .rstn(rstn), .cfg_w_i(cfg_w_i), .cfg_h_i(cfg_h_i),
    .start_i(start_i), .pix_val_i(pix_val_i), .pix_dat_i(pix_dat_i),
    .pix_rdy_o(pix_rdy_o), .fifo_wr_val_o(fifo_wr_val_o),
    .fifo_wr_dat_o(fifo_wr_dat_o), .fifo_rd_val_o(fifo_rd_val_o),
    .fifo_rd_dat_i(fifo_rd_dat_i), .out_val_o(out_val_o),
    .out_cur_o(out_cur_o), .out_a_o(out_a_o), .out_b_o(out_b_o),
    .out_c_o(out_c_o), .out_sol_o(out_sol_o), .out_eof_o(out_eof_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Single-port line FIFO: pointers wrap at the image width.
  logic [DW-1:0] fmem [0:255];
  int            cur_w = 1;
  int            wp, rp;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= 0;
      rp <= 0;
      fifo_rd_dat_i <= '0;
    end else begin
      if (fifo_wr_val_o) begin
        fmem[wp] <= fifo_wr_dat_o;
        wp <= (wp == cur_w - 1) ? 0 : wp + 1;
      end
      if (fifo_rd_val_o) begin
        fifo_rd_dat_i <= fmem[rp];
        rp <= (rp == cur_w - 1) ? 0 : rp + 1;
      end
    end
  end

  typedef struct {
    logic [DW-1:0] cur, a, b, c;
    logic          sol, eof;
  } nb_t;
  nb_t           exp_q[$];
  logic [DW-1:0] img [0:7][0:7];

  int   wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  logic prev_rd = 1'b0, prev_eof_out = 1'b0;

  always @(negedge clk) begin
    nb_t e;
    if (!rstn) begin
      prev_rd      = 1'b0;
      prev_eof_out = 1'b0;
    end else begin
      if (fifo_rd_val_o || fifo_wr_val_o)
        check("strobe_overlap", 64'(fifo_rd_val_o & fifo_wr_val_o), 0);
      if (fifo_rd_val_o) begin
        rd_cnt++;
        check("rd_without_xfer", 64'(pix_val_i & pix_rdy_o), 1);
      end
      if (fifo_wr_val_o) wr_cnt++;
      if (prev_rd) check("rdy_after_rd", 64'(pix_rdy_o), 0);
      if (out_val_o) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("cur", out_cur_o, e.cur);
          check("a",   out_a_o,   e.a);
          check("b",   out_b_o,   e.b);
          check("c",   out_c_o,   e.c);
          check("sol", 64'(out_sol_o), 64'(e.sol));
          check("eof", 64'(out_eof_o), 64'(e.eof));
        end
      end
      if (done_o) begin
        done_cnt++;
        check("done_after_eof", 64'(prev_eof_out), 1);
      end
      prev_rd      = fifo_rd_val_o;
      prev_eof_out = out_val_o & out_eof_o;
    end
  end

  task automatic fill_random(input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int x = 0; x < w; x++) img[r][x] = $urandom;
  endtask

  task automatic send_pixel(input logic [DW-1:0] d, input int gap_pct);
    int t;
    while ($urandom_range(99) < gap_pct) begin
      pix_val_i = 1'b0;
      pix_dat_i = $urandom;
      @(posedge clk); #1;
    end
    pix_val_i = 1'b1;
    pix_dat_i = d;
    t = 0;
    while (!pix_rdy_o && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!pix_rdy_o) check("rdy_timeout", 0, 1);
    @(posedge clk); #1;
    pix_val_i = 1'b0;
    pix_dat_i = $urandom;
  endtask

  // start_at: pixel index before which a stray start_i is pulsed.
  // abort_at: pixel index at which rstn is asserted instead of continuing.
  task automatic run_frame(input int w, input int h, input int gap_pct,
                           input int start_at, input int abort_at);
    nb_t e;
    int  d0, t;
    wr_cnt  = 0;
    rd_cnt  = 0;
    d0      = done_cnt;
    cfg_w_i = `SIZE_W_WD'(w);
    cfg_h_i = `SIZE_H_WD'(h);
    cur_w   = w;
    for (int r = 0; r < h; r++)
      for (int x = 0; x < w; x++) begin
        e.cur = img[r][x];
        e.a   = (x > 0) ? img[r][x-1] : '0;
        e.b   = (r > 0) ? img[r-1][x] : '0;
        e.c   = (r > 0 && x > 0) ? img[r-1][x-1] : '0;
        e.sol = (x == 0);
        e.eof = (r == h - 1) && (x == w - 1);
        exp_q.push_back(e);
      end
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 0; k < w * h; k++) begin
      if (k == abort_at) begin
        rstn = 1'b0;
        #1;
        check("rst_out_val", 64'(out_val_o), 0);
        check("rst_cur",     out_cur_o, 0);
        check("rst_rdy",     64'(pix_rdy_o), 0);
        check("rst_strobes", 64'({fifo_wr_val_o, fifo_rd_val_o, done_o}), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        return;
      end
      if (k == start_at) begin
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
      end
      send_pixel(img[k / w][k % w], gap_pct);
    end
    t = 0;
    while (done_cnt == d0 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("done_count",  64'(done_cnt - d0), 1);
    check("writes",      64'(wr_cnt), 64'(w * h));
    check("reads",       64'(rd_cnt), 64'((h - 1) * w));
    check("exp_drained", 64'(exp_q.size()), 0);
    check("idle_rdy",    64'(pix_rdy_o), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy",   64'(pix_rdy_o), 0);
    check("reset_val",   64'(out_val_o), 0);
    check("reset_done",  64'(done_o), 0);
    check("reset_wr",    64'(fifo_wr_val_o), 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("idle_no_rdy", 64'(pix_rdy_o), 0);

    for (int i = 0; i < 4; i++) img[0][i] = DW'(i + 1);
    run_frame(4, 1, 0, -1, -1);

    img[0][0] = 10; img[0][1] = 11; img[0][2] = 12;
    img[1][0] = 20; img[1][1] = 21; img[1][2] = 22;
    run_frame(3, 2, 0, -1, -1);

    fill_random(3, 3);
    run_frame(3, 3, 40, -1, -1);

    img[0][0] = 5; img[1][0] = 6; img[2][0] = 7;
    run_frame(1, 3, 0, -1, -1);

    fill_random(4, 3);
    run_frame(4, 3, 0, -1, 6);
    fill_random(2, 2);
    run_frame(2, 2, 0, -1, -1);

    fill_random(3, 2);
    run_frame(3, 2, 0, 4, -1);

    for (int i = 0; i < 6; i++) begin
      int w, h;
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 4);
      fill_random(w, h);
      run_frame(w, h, 30, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/line_fifo_ctrl.md
Name: line_fifo_ctrl

Overview:
- Sequences the single-port, write-priority line FIFO that holds the previous image row for the PNG filter stage.
- For every incoming pixel it issues a read of the same column from the previous row, then writes the current pixel into that slot.
- Emits a neighbour set {cur, left a, up b, upleft c} per pixel to the filter/Paeth unit.
- Sits between the pixel source and the filter datapath; owns all FIFO read/write strobes.

Parameters:
- DATA_WD, 32: pixel width in bits; equals the FIFO DATA_WD.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock, asynchronous, active-low
- cfg_w_i  in  `SIZE_W_WD  image width in pixels, ≥1, same value as the FIFO cfg_w_i
- cfg_h_i  in  `SIZE_H_WD  image height in rows, ≥1
- start_i  in  1  one-cycle frame start pulse
- pix_val_i  in  1  input pixel valid
- pix_dat_i  in  DATA_WD  input pixel
- pix_rdy_o  out  1  input pixel ready; transfer occurs when val & rdy
- fifo_wr_val_o  out  1  FIFO write strobe
- fifo_wr_dat_o  out  DATA_WD  FIFO write data
- fifo_rd_val_o  out  1  FIFO read strobe
- fifo_rd_dat_i  in  DATA_WD  FIFO read data, valid one cycle after fifo_rd_val_o
- out_val_o  out  1  neighbour set valid, one-cycle pulse
- out_cur_o / out_a_o / out_b_o / out_c_o  out  DATA_WD each  current / left / up / upleft pixel
- out_sol_o  out  1  with out_val_o: first pixel of a row
- out_eof_o  out  1  with out_val_o: last pixel of the frame
- done_o  out  1  one-cycle pulse after the last output

Behaviour:
- Reset: all registered outputs are 0; FSM enters IDLE; column and row counters are 0.
- Downstream has no backpressure: the consumer must accept every out_val_o.
- FSM transitions:
  - IDLE: pix_rdy_o=0. On start_i, go to ROW0. start_i is ignored in every other state; there is no abort.
  - ROW0 (row 0): pix_rdy_o=1.
    - Each transfer drives fifo_wr_val_o=1 and fifo_wr_dat_o=pix_dat_i in the same cycle (combinational).
    - Output is registered with latency 1: cur=pixel, b=c=0, a=previous cur (0 at column 0).
    - After column cfg_w-1: go to RD if cfg_h>1, otherwise to DONE.
  - RD (rows ≥1): pix_rdy_o=1.
    - On transfer: fifo_rd_val_o=1 (combinational, same cycle), capture the pixel into a hold register, go to WR.
    - With no transfer: stay, no strobes.
  - WR: pix_rdy_o=0, fifo_wr_val_o=1, fifo_wr_dat_o=hold register.
    - Capture fifo_rd_dat_i as up.
    - Register the output (latency 2 from transfer): cur=hold, b=up, a=previous cur, c=previous up.
    - a=c=0 at column 0.
    - Next state: after the last column of the last row go to DONE, otherwise RD.
  - DONE: pulse done_o=1 for one cycle, go to IDLE.
- fifo_rd_val_o and fifo_wr_val_o are never high in the same cycle.
- Throughput: row 0 is 1 pixel/cycle; rows ≥1 are 1 pixel/2 cycles.
- Counters:
  - Column counter wraps cfg_w-1→0 and increments the row counter.
  - The FIFO pointers use the same wrap, so read column x always precedes write column x.
  - A full frame writes h·w and reads (h−1)·w entries, leaving both FIFO pointers at 0.
- Flags: out_sol_o=1 when column=0; out_eof_o=1 on the final pixel (last row, column cfg_w-1).
- cfg_w=1: a=c=0 on every pixel.
- cfg_h=1: the frame is ROW0 only.
- cfg_* must be stable from start_i until done_o.
- Reset mid-frame: immediate return to IDLE with all outputs 0. The FIFO shares rstn, so its pointers realign.

Test Plan:
- w=4, h=1, pixels 1..4 streamed continuously → 4 writes, 0 reads; outputs (cur,a,b,c)=(1,0,0,0),(2,1,0,0),(3,2,0,0),(4,3,0,0); eof on 4; done_o the following cycle.
- w=3, h=2, row0=10,11,12, row1=20,21,22 → row1 outputs (20,0,10,0),(21,20,11,10),(22,21,12,11); pix_rdy_o alternates 1/0 in row 1; read and write strobes never overlap.
- w=3, h=3, pix_val_i deasserted randomly → identical outputs to the continuous case; no strobe issued while val=0.
- w=1, h=3, pixels 5,6,7 → (5,0,0,0),(6,0,5,0),(7,0,6,0); sol and eof flags correct.
- rstn asserted in the middle of row 1 of a w=4, h=3 frame, then a new frame with w=2, h=2 → the new frame's up values come only from its own row 0.
- start_i pulsed mid-frame → ignored; frame completes normally with exactly one done_o.
